nes_poll_sched: RTL and testbench

Poll scheduler and CPU-facing register block for the NES controller serial bridge. It fires bridge transactions periodically or on software request and supervises each one with a timeout. It latches the returned button byte, detects button changes and raises an interrupt. It sits between the CPU's memory-mapped peripheral bus and the bridge's `start`/result handshake.

---
 rtl/nes_poll_sched.sv | 195 +++++++++++++++++++
 tb/tb_nes_poll_sched.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_poll_sched.sv
// Poll scheduler and CPU register block for the NES controller serial bridge.
// Launches bridge transactions periodically or on a software one-shot, supervises
// each with a timeout, latches the returned button byte and flags changes.
module nes_poll_sched #(
  parameter logic [23:0] DEFAULT_PERIOD = 24'd1_000_000,
  parameter logic [19:0] TIMEOUT        = 20'd100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [31:0] bus_rdata,
  output logic        irq,
  output logic        br_start,
  input  logic        br_busy,
  input  logic        br_done,
  input  logic        br_nack,
  input  logic [7:0]  br_data
);

  localparam logic [2:0] AddrCtrl    = 3'd0;
  localparam logic [2:0] AddrPeriod  = 3'd1;
  localparam logic [2:0] AddrStatus  = 3'd2;
  localparam logic [2:0] AddrButtons = 3'd3;
  localparam logic [2:0] AddrCount   = 3'd4;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_e;

  state_e      state_q, state_d;
  logic        en_q, irq_en_q, pending_q, pending_d;
  logic [23:0] period_q, pcnt_q;
  logic [19:0] tcnt_q;
  logic        valid_q, err_q, changed_q;
  logic [7:0]  cur_q, prev_q, data_q;
  logic        nack_q;
  logic [15:0] count_q;
  logic [31:0] rdata_q, rd_mux;

  logic wr_ctrl, wr_period, wr_status;
  logic tick, launch, timed_out, timeout_evt, cap_good, cap_bad;

  // Only PERIOD consumes the upper write-data bits up to 23; the top byte is unused.
  logic unused_wdata;
  assign unused_wdata = ^bus_wdata[31:24];

  assign wr_ctrl   = bus_we && (bus_addr == AddrCtrl);
  assign wr_period = bus_we && (bus_addr == AddrPeriod);
  assign wr_status = bus_we && (bus_addr == AddrStatus);

  // >= rather than == so a PERIOD shrunk below the running count wraps at once.
  assign tick      = en_q && (period_q != 24'd0) && (pcnt_q >= period_q - 24'd1);
  assign launch    = (state_q == StIdle) && (tick || pending_q);
  assign timed_out = tcnt_q >= TIMEOUT - 20'd1;
  assign cap_good  = (state_q == StCapture) && !nack_q;
  assign cap_bad   = (state_q == StCapture) && nack_q;

  assign irq       = irq_en_q & changed_q;
  assign bus_rdata = rdata_q;

  // Next-state logic; br_start is decoded straight from the ISSUE state.
  always_comb begin
    state_d     = state_q;
    br_start    = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      StIdle: begin
        if (launch) state_d = StIssue;
      end
      StIssue: begin
        br_start = 1'b1;
        if (br_done) begin
          state_d = StCapture;
        end else if (br_busy) begin
          state_d = StWait;
        end else if (timed_out) begin
          // A bridge that never acknowledges must not wedge the scheduler.
          state_d     = StIdle;
          timeout_evt = 1'b1;
        end
      end
      StWait: begin
        if (br_done) begin
          state_d = StCapture;
        end else if (timed_out) begin
          state_d     = StIdle;
          timeout_evt = 1'b1;
        end
      end
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // One-shot request: a launch consumes it, including a write landing on the launch edge.
  always_comb begin
    pending_d = pending_q;
    if (wr_ctrl && bus_wdata[2]) pending_d = 1'b1;
    if (launch) pending_d = 1'b0;
  end

  // FSM state, period counter, timeout counter and bridge result latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      pcnt_q    <= 24'd0;
      tcnt_q    <= 20'd0;
      data_q    <= 8'd0;
      nack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      // The period counter keeps running during a transaction; ticks there are dropped.
      if (!en_q || period_q == 24'd0 || tick) begin
        pcnt_q <= 24'd0;
      end else begin
        pcnt_q <= pcnt_q + 24'd1;
      end
      if (state_q == StIssue || state_q == StWait) begin
        tcnt_q <= tcnt_q + 20'd1;
      end else begin
        tcnt_q <= 20'd0;
      end
      if ((state_q == StIssue || state_q == StWait) && br_done) begin
        data_q <= br_data;
        nack_q <= br_nack;
      end
    end
  end

  // CPU-visible registers; hardware set of a sticky bit wins over a W1C in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      period_q  <= DEFAULT_PERIOD;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      changed_q <= 1'b0;
      cur_q     <= 8'd0;
      prev_q    <= 8'd0;
      count_q   <= 16'd0;
    end else begin
      if (wr_ctrl) begin
        en_q     <= bus_wdata[0];
        irq_en_q <= bus_wdata[1];
      end
      if (wr_period) period_q <= bus_wdata[23:0];

      if (timeout_evt || cap_bad) begin
        err_q <= 1'b1;
      end else if (wr_status && bus_wdata[2]) begin
        err_q <= 1'b0;
      end

      if (cap_good && (!valid_q || data_q != cur_q)) begin
        changed_q <= 1'b1;
      end else if (wr_status && bus_wdata[3]) begin
        changed_q <= 1'b0;
      end

      if (cap_good) begin
        prev_q  <= cur_q;
        cur_q   <= data_q;
        valid_q <= 1'b1;
        count_q <= count_q + 16'd1;
      end
    end
  end

  // Register read decode; unmapped indices read zero.
  always_comb begin
    rd_mux = 32'd0;
    case (bus_addr)
      AddrCtrl:    rd_mux = {30'd0, irq_en_q, en_q};
      AddrPeriod:  rd_mux = {8'd0, period_q};
      AddrStatus:  rd_mux = {28'd0, changed_q, err_q, valid_q, state_q != StIdle};
      AddrButtons: rd_mux = {16'd0, prev_q, cur_q};
      AddrCount:   rd_mux = {16'd0, count_q};
      default:     rd_mux = 32'd0;
    endcase
  end

  // Read data is registered and held at zero outside the cycle after a read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'd0;
    end else begin
      rdata_q <= bus_re ? rd_mux : 32'd0;
    end
  end

endmodule

// File: tb/tb_nes_poll_sched.sv
// Self-checking bench for nes_poll_sched: register vector tables, a bridge model,
// a read scoreboard and hand-written timing sequences.
module tb_nes_poll_sched;

  localparam logic [23:0] DefPeriod = 24'd1000;
  localparam logic [19:0] Tmo       = 20'd400;
  localparam int          TmoCyc    = 400;

  logic        clk;
  logic        rst;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata;
  logic        irq;
  logic        br_start;
  logic        br_busy;
  logic        br_done;
  logic        br_nack;
  logic [7:0]  br_data;

  nes_poll_sched #(
    .DEFAULT_PERIOD(DefPeriod),
    .TIMEOUT       (Tmo)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_we   (bus_we),
    .bus_re   (bus_re),
    .bus_rdata(bus_rdata),
    .irq      (irq),
    .br_start (br_start),
    .br_busy  (br_busy),
    .br_done  (br_done),
    .br_nack  (br_nack),
    .br_data  (br_data)
  );

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model of the register contents.
  logic [7:0] m_cur, m_prev;
  logic       m_val, m_err, m_chg;
  int         m_cnt;

  task automatic model_reset();
    m_cur = 8'd0; m_prev = 8'd0; m_val = 1'b0; m_err = 1'b0; m_chg = 1'b0; m_cnt = 0;
  endtask

  function automatic logic [31:0] st(input logic busy);
    return {28'd0, m_chg, m_err, m_val, busy};
  endfunction

  function automatic logic [31:0] btn();
    return {16'd0, m_prev, m_cur};
  endfunction

  // Read scoreboard: expectation queued when the strobe is driven, checked when data returns.
  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb_q[$];

  bit re_d;
  bit busy_seen;
  bit start_prev;
  int nrise = 0;
  int rise_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
    re_d      = bus_re;
    busy_seen = br_busy | br_done;
  end

  initial forever begin
    @(negedge clk);
    if (re_d) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_read", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check(e.name, bus_rdata, e.exp);
      end
    end
    if (busy_seen) check("start_after_busy", {31'd0, br_start}, 32'd0);
    if (br_start && !start_prev) begin
      nrise++;
      rise_q.push_back(cyc);
    end
    start_prev = br_start;
  end

  function automatic int rise_at(input int i);
    if (i < rise_q.size()) return rise_q[i];
    return -1;
  endfunction

  // Bridge model: answers each br_start after b_lat cycles with b_data / b_nack.
  int         b_lat  = 10;
  logic [7:0] b_data = 8'd0;
  bit         b_nack, b_hang, b_ignore, b_abort, b_stale, b_act;
  int         b_cnt;
  int         ndone    = 0;
  int         done_cyc = 0;

  initial begin
    br_busy = 1'b0; br_done = 1'b0; br_nack = 1'b0; br_data = 8'd0;
    forever begin
      @(negedge clk);
      if (br_done) begin
        br_done = 1'b0; br_nack = 1'b0; br_data = 8'd0;
      end
      if (b_act) begin
        if (b_abort) begin
          b_act = 1'b0; br_busy = 1'b0; b_abort = 1'b0;
        end else if (!b_hang && b_cnt >= b_lat) begin
          br_busy = 1'b0; br_done = 1'b1; br_nack = b_nack; br_data = b_data;
          b_act = 1'b0; ndone++; done_cyc = cyc;
          if (!b_stale) begin
            if (b_nack) begin
              m_err = 1'b1;
            end else begin
              if (!m_val || b_data != m_cur) m_chg = 1'b1;
              m_prev = m_cur; m_cur = b_data; m_val = 1'b1; m_cnt++;
            end
          end
          b_stale = 1'b0;
        end else begin
          b_cnt++;
        end
      end else begin
        b_abort = 1'b0;
        if (br_start && !b_ignore) begin
          b_act = 1'b1; br_busy = 1'b1; b_cnt = 1;
        end
      end
    end
  end

  // Bus tasks: called just after a negedge, return at a later negedge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; bus_wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] e, input string n);
    sb_t s;
    s.exp = e; s.name = n;
    sb_q.push_back(s);
    bus_addr = a; bus_re = 1'b1;
    @(negedge clk);
    bus_re = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rise(input int n, input int budget, input string name);
    int k = 0;
    while (nrise < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, nrise >= n}, 32'd1);
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    int k = 0;
    while (ndone < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, ndone >= n}, 32'd1);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t rst_vec[7];
  vec_t reg_vec[14];

  task automatic apply(input vec_t v);
    if (v.we) bus_write(v.addr, v.wdata);
    else bus_read(v.addr, v.exp, v.name);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: run exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int w, base, bd, r;

  initial begin
    rst_vec[0] = '{1'b0, 3'd0, 32'd0, 32'd0, "rst_ctrl"};
    rst_vec[1] = '{1'b0, 3'd1, 32'd0, {8'd0, DefPeriod}, "rst_period"};
    rst_vec[2] = '{1'b0, 3'd2, 32'd0, 32'd0, "rst_status"};
    rst_vec[3] = '{1'b0, 3'd3, 32'd0, 32'd0, "rst_buttons"};
    rst_vec[4] = '{1'b0, 3'd4, 32'd0, 32'd0, "rst_count"};
    rst_vec[5] = '{1'b0, 3'd5, 32'd0, 32'd0, "rst_unmapped5"};
    rst_vec[6] = '{1'b0, 3'd7, 32'd0, 32'd0, "rst_unmapped7"};

    reg_vec[0]  = '{1'b1, 3'd1, 32'h0000_0123, 32'd0, ""};
    reg_vec[1]  = '{1'b0, 3'd1, 32'd0, 32'h0000_0123, "period_rw"};
    reg_vec[2]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'd0, ""};
    reg_vec[3]  = '{1'b0, 3'd1, 32'd0, 32'h00FF_FFFF, "period_width"};
    reg_vec[4]  = '{1'b1, 3'd0, 32'h0000_0002, 32'd0, ""};
    reg_vec[5]  = '{1'b0, 3'd0, 32'd0, 32'h0000_0002, "ctrl_irq_en"};
    reg_vec[6]  = '{1'b1, 3'd0, 32'h0000_0000, 32'd0, ""};
    reg_vec[7]  = '{1'b0, 3'd0, 32'd0, 32'h0000_0000, "ctrl_clear"};
    reg_vec[8]  = '{1'b1, 3'd5, 32'hFFFF_FFFF, 32'd0, ""};
    reg_vec[9]  = '{1'b0, 3'd5, 32'd0, 32'd0, "unmapped_write"};
    reg_vec[10] = '{1'b1, 3'd2, 32'h0000_000F, 32'd0, ""};
    reg_vec[11] = '{1'b0, 3'd2, 32'd0, 32'd0, "status_ro"};
    reg_vec[12] = '{1'b1, 3'd6, 32'h0000_0005, 32'd0, ""};
    reg_vec[13] = '{1'b0, 3'd6, 32'd0, 32'd0, "unmapped6"};

    rst = 1'b1; bus_addr = 3'd0; bus_wdata = 32'd0; bus_we = 1'b0; bus_re = 1'b0;
    model_reset();
    idle(3);
    check("rst_br_start", {31'd0, br_start}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);
    rst = 1'b0;
    idle(1);
    for (int i = 0; i < 7; i++) apply(rst_vec[i]);
    for (int i = 0; i < 14; i++) apply(reg_vec[i]);

    // Periodic polling with PERIOD=100.
    b_lat = 50; b_data = 8'hA5; b_nack = 1'b0;
    bus_write(3'd1, 32'd100);
    base = nrise; w = cyc + 1;
    bus_write(3'd0, 32'd1);
    wait_rise(base + 1, 150, "per_rise1");
    check("per_first_at_period", rise_at(base) - w, 32'd100);
    idle(60);
    bus_read(3'd3, btn(), "per_buttons1");
    check("per_buttons1_model", btn(), 32'h0000_00A5);
    bus_read(3'd4, 32'd1, "per_count1");
    bus_read(3'd2, st(1'b0), "per_status1");
    wait_rise(base + 3, 250, "per_rise3");
    check("per_interval2", rise_at(base + 1) - rise_at(base), 32'd100);
    check("per_interval3", rise_at(base + 2) - rise_at(base + 1), 32'd100);
    bus_write(3'd0, 32'd0);
    idle(70);
    bus_read(3'd4, 32'd3, "per_count3");
    bus_read(3'd3, 32'h0000_A5A5, "per_buttons3");
    idle(150);
    check("per_disabled_no_rise", nrise, base + 3);

    // One-shot and change detection.
    bus_write(3'd2, 32'h8);
    m_chg = 1'b0;
    b_lat = 10; b_data = 8'h01;
    base = nrise; bd = ndone; w = cyc + 1;
    bus_write(3'd0, 32'h6);
    wait_rise(base + 1, 10, "os_rise");
    check("os_latency", rise_at(base) - w, 32'd1);
    wait_done(bd + 1, 40, "os_done1");
    wait_cyc(done_cyc + 1);
    check("os_irq_pre", {31'd0, irq}, 32'd0);
    idle(1);
    check("os_irq_set", {31'd0, irq}, 32'd1);
    bus_write(3'd2, 32'h8);
    m_chg = 1'b0;
    check("os_irq_w1c", {31'd0, irq}, 32'd0);
    bd = ndone;
    bus_write(3'd0, 32'h6);
    wait_done(bd + 1, 40, "os_done2");
    idle(4);
    check("os_irq_same_data", {31'd0, irq}, 32'd0);
    b_data = 8'h03;
    bd = ndone;
    bus_write(3'd0, 32'h6);
    wait_done(bd + 1, 40, "os_done3");
    wait_cyc(done_cyc + 1);
    // W1C of changed lands on the capture edge; the capture must win.
    bus_write(3'd2, 32'h8);
    check("os_irq_set_wins", {31'd0, irq}, 32'd1);
    bus_read(3'd3, 32'h0000_0103, "os_buttons");
    bus_read(3'd4, 32'd6, "os_count");
    bus_write(3'd2, 32'h8);
    m_chg = 1'b0;
    check("os_irq_cleared", {31'd0, irq}, 32'd0);
    bus_write(3'd0, 32'h0);

    // Timeout: the bridge stays busy and never reports done.
    b_hang = 1'b1;
    base = nrise;
    bus_write(3'd0, 32'h4);
    wait_rise(base + 1, 10, "to_rise");
    r = rise_at(base);
    wait_cyc(r + TmoCyc - 1);
    begin
      sb_t s;
      s.exp = st(1'b1); s.name = "to_status_before";
      sb_q.push_back(s);
      bus_addr = 3'd2; bus_re = 1'b1;
      @(negedge clk);
      m_err = 1'b1;
      s.exp = st(1'b0); s.name = "to_status_at_timeout";
      sb_q.push_back(s);
      @(negedge clk);
      bus_re = 1'b0;
    end
    b_abort = 1'b1; b_hang = 1'b0;
    idle(3);
    bus_read(3'd3, 32'h0000_0103, "to_buttons_kept");
    bus_read(3'd4, 32'd6, "to_count_kept");
    bus_write(3'd2, 32'h4);
    m_err = 1'b0;
    bus_read(3'd2, st(1'b0), "to_err_w1c");

    // NACK from a clean reset.
    rst = 1'b1; idle(2); rst = 1'b0; model_reset();
    b_nack = 1'b1; b_data = 8'hFF; b_lat = 5;
    bd = ndone;
    bus_write(3'd0, 32'h4);
    wait_done(bd + 1, 30, "nack_done");
    idle(4);
    bus_read(3'd2, 32'h0000_0004, "nack_status");
    bus_read(3'd3, 32'd0, "nack_buttons");
    bus_read(3'd4, 32'd0, "nack_count");
    b_nack = 1'b0;

    // One-shot written on the same edge as a periodic tick: one launch only.
    b_lat = 20; b_data = 8'h5A;
    bus_write(3'd1, 32'd100);
    base = nrise; w = cyc + 1;
    bus_write(3'd0, 32'd1);
    wait_cyc(w + 99);
    bus_write(3'd0, 32'd5);
    wait_cyc(w + 150);
    bus_write(3'd0, 32'd0);
    wait_cyc(w + 260);
    check("coll_single_rise", nrise, base + 1);
    check("coll_rise_cyc", rise_at(base) - w, 32'd100);

    // Ticks during a long transaction are dropped, not queued.
    b_lat = 300;
    base = nrise; w = cyc + 1;
    bus_write(3'd0, 32'd1);
    wait_rise(base + 2, 600, "drop_rises");
    check("drop_first", rise_at(base) - w, 32'd100);
    check("drop_next", rise_at(base + 1) - w, 32'd500);
    bus_write(3'd0, 32'd0);
    idle(320);

    // Shrinking PERIOD below the running count wraps on the next cycle.
    b_lat = 5;
    bus_write(3'd1, 32'd200);
    base = nrise; w = cyc + 1;
    bus_write(3'd0, 32'd1);
    wait_cyc(w + 149);
    bus_write(3'd1, 32'd100);
    wait_rise(base + 1, 20, "shrink_rise");
    check("shrink_wrap", rise_at(base) - w, 32'd151);
    wait_rise(base + 2, 120, "shrink_rise2");
    check("shrink_interval", rise_at(base + 1) - rise_at(base), 32'd100);
    bus_write(3'd0, 32'd0);
    idle(10);

    // Reset while in ISSUE drops br_start on the next cycle.
    b_ignore = 1'b1;
    base = nrise;
    bus_write(3'd0, 32'h4);
    wait_rise(base + 1, 10, "ri_rise");
    check("ri_start_high", {31'd0, br_start}, 32'd1);
    rst = 1'b1;
    idle(1);
    check("ri_start_dropped", {31'd0, br_start}, 32'd0);
    rst = 1'b0; model_reset(); b_ignore = 1'b0;
    idle(2);

    // Reset mid-WAIT; the late br_done must not be captured.
    b_lat = 5; b_data = 8'h77;
    bus_write(3'd1, 32'd100);
    bd = ndone;
    bus_write(3'd0, 32'h6);
    wait_done(bd + 1, 30, "rw_pre_done");
    idle(4);
    check("rw_pre_irq", {31'd0, irq}, 32'd1);
    b_lat = 100; b_data = 8'h3C;
    base = nrise; bd = ndone;
    bus_write(3'd0, 32'h6);
    wait_rise(base + 1, 10, "rw_rise");
    idle(20);
    b_stale = 1'b1;
    rst = 1'b1;
    idle(1);
    check("rw_start", {31'd0, br_start}, 32'd0);
    check("rw_irq", {31'd0, irq}, 32'd0);
    check("rw_rdata", bus_rdata, 32'd0);
    rst = 1'b0; model_reset();
    for (int i = 0; i < 7; i++) apply(rst_vec[i]);
    wait_done(bd + 1, 150, "rw_late_done");
    idle(4);
    bus_read(3'd2, 32'd0, "rw_late_status");
    bus_read(3'd3, 32'd0, "rw_late_buttons");
    bus_read(3'd4, 32'd0, "rw_late_count");
    check("rw_no_relaunch", nrise, base + 1);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
